uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Transmit-side byte buffer and send sequencer that sits directly upstream of the UART transmitter. It accepts bytes from the CPU/host side into a circular FIFO. It then presents them one at a time on the transmitter's data input and drives its send trigger. It uses the transmitter's sending flag as the handshake: it holds a byte until transmission starts and pops the byte when transmission ends.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
ADDR_W, 4, log2(DEPTH)
START_TIMEOUT, 4096, clocks to wait for tx_busy to rise after tx_send asserts; minimum 2, must fit in 16 bits

Ports:
clock  in  1  system clock; all logic on the rising edge
reset_uart  in  1  asynchronous, active-high reset
enable  in  1  permits new sends when high; an in-flight byte always completes
wr_en  in  1  write strobe from host
wr_data  in  8  byte to enqueue
clear_flags  in  1  synchronous clear of overflow and tx_timeout
tx_busy  in  1  transmitter's sending flag
d_in  out  8  byte to transmitter; registered
tx_send  out  1  send request to transmitter; registered
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  ADDR_W+1  entries held, including the byte in flight
overflow  out  1  sticky: a write was dropped
tx_timeout  out  1  sticky: tx_busy did not rise within START_TIMEOUT

Behaviour:
- Reset (asynchronous, active-high), effective immediately:
  - wr_ptr, rd_ptr, count, timer = 0; state = IDLE.
  - d_in = 8'h00, tx_send = 0, overflow = 0, tx_timeout = 0.
  - FIFO contents are not cleared.
- Reset mid-transfer abandons the byte. The FIFO is empty after reset.
- Write: on an edge with wr_en=1 and full=0, mem[wr_ptr] <= wr_data, wr_ptr increments and wraps modulo DEPTH.
- Write while full: the byte is dropped and overflow is set. This holds even if a pop occurs on the same edge, because full is evaluated on registered count.
- Pop: occurs only on the WAIT_DONE exit edge; rd_ptr increments and wraps.
- Count update: +1 on accepted write only; -1 on pop only; unchanged when both happen on the same edge. count never exceeds DEPTH and never underflows.
- full and empty are combinational decodes of registered count.
- The head byte stays in the FIFO, and is counted, until its transmission completes.
- FSM states:
  - IDLE: tx_send = 0. If enable=1, empty=0 and tx_busy=0: d_in <= mem[rd_ptr], tx_send <= 1, timer <= 0, go to SEND.
  - SEND: tx_send is held at 1 and timer increments each clock.
    - If tx_busy=1: tx_send <= 0, go to WAIT_DONE. tx_busy has priority over timeout.
    - Else if timer == START_TIMEOUT-1: tx_send <= 0, tx_timeout <= 1, go to IDLE. No pop; the same byte is retried from IDLE.
  - WAIT_DONE: tx_send = 0. When tx_busy=0: pop, go to IDLE.
- d_in is stable from SEND entry until the next IDLE->SEND edge.
- Latency: write on edge k into an empty FIFO, with enable=1 and tx_busy=0:
  - count = 1 after edge k;
  - d_in valid and tx_send = 1 after edge k+1.
- Back-to-back bytes: the next IDLE->SEND occurs no earlier than 1 clock after the WAIT_DONE exit edge, so tx_send is low for at least 1 clock between bytes.
- enable dropped:
  - in SEND or WAIT_DONE: has no effect; the current byte completes;
  - in IDLE: the FSM stays in IDLE.
- clear_flags: overflow and tx_timeout <= 0. A set event on the same edge wins, so the flag stays at 1.
- tx_busy already high while the FSM is in IDLE (transmitter busy from elsewhere): the FSM waits in IDLE.

Test Plan:
- Reset, then write 8'hA5 at edge k, tx_busy tied low -> count=1 after k; d_in=8'hA5 and tx_send=1 after edge k+1; tx_send stays high; tx_timeout=1 after START_TIMEOUT clocks; byte retried; count remains 1.
- Write 8'h55, 8'h0F, 8'hF0; model transmitter raising tx_busy 3 clocks after tx_send and holding it 20 clocks -> d_in sequence 55, 0F, F0; one tx_send pulse per byte, each falling on the tx_busy rise edge; count 3->2->1->0; tx_send low at least 1 clock between bytes.
- With enable=0, write DEPTH+1 bytes 8'h00..8'h10 -> full=1, count=16, overflow=1; then clear_flags -> overflow=0; enable=1 -> 8'h00..8'h0F transmitted in order; 8'h10 never appears; pointers wrap.
- FIFO full, WAIT_DONE exit edge coinciding with wr_en -> write dropped, overflow=1, count=15 afterwards.
- Assert reset_uart during WAIT_DONE with 4 bytes queued -> tx_send=0, d_in=8'h00, count=0, empty=1 immediately; after release a fresh write is sent normally.
- Drop enable while in SEND -> handshake completes; the byte pops; no new send occurs until enable=1.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Host-side and transmitter-side signals of the UART transmit buffer.
// master = host/transmitter environment, slave = the buffer itself.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              enable;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              clear_flags;
  logic              tx_busy;
  logic [7:0]        d_in;
  logic              tx_send;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              tx_timeout;

  modport master (
    output enable, wr_en, wr_data, clear_flags, tx_busy,
    input  d_in, tx_send, full, empty, count, overflow, tx_timeout
  );

  modport slave (
    input  enable, wr_en, wr_data, clear_flags, tx_busy,
    output d_in, tx_send, full, empty, count, overflow, tx_timeout
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO plus send sequencer: holds the head byte until the
// transmitter's busy flag rises, pops it once busy falls again.
module uart_tx_fifo #(
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int START_TIMEOUT = 4096
) (
  input  logic          clock,
  input  logic          reset_uart,
  uart_tx_fifo_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state_reg;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [15:0]       timer_reg;
  logic [7:0]        d_in_reg;
  logic              tx_send_reg;
  logic              overflow_reg;
  logic              tx_timeout_reg;

  logic full;
  logic empty;
  logic wr_accept;
  logic pop;
  logic timeout_hit;

  // full is decoded from registered count, so a pop on the same edge
  // does not make room for a write.
  assign full        = (count_reg == (ADDR_W+1)'(DEPTH));
  assign empty       = (count_reg == '0);
  assign wr_accept   = bus.wr_en && !full;
  assign pop         = (state_reg == WAIT_DONE) && !bus.tx_busy;
  assign timeout_hit = (state_reg == SEND) && !bus.tx_busy &&
                       (timer_reg == 16'(START_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset_uart) begin
    if (reset_uart) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)       rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_accept, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky flags: a set event on the clearing edge keeps the flag high.
  always_ff @(posedge clock or posedge reset_uart) begin
    if (reset_uart) begin
      overflow_reg   <= 1'b0;
      tx_timeout_reg <= 1'b0;
    end else begin
      overflow_reg   <= (overflow_reg && !bus.clear_flags) || (bus.wr_en && full);
      tx_timeout_reg <= (tx_timeout_reg && !bus.clear_flags) || timeout_hit;
    end
  end

  always_ff @(posedge clock or posedge reset_uart) begin
    if (reset_uart) begin
      state_reg   <= IDLE;
      d_in_reg    <= 8'h00;
      tx_send_reg <= 1'b0;
      timer_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_send_reg <= 1'b0;
          if (bus.enable && !empty && !bus.tx_busy) begin
            d_in_reg    <= mem[rd_ptr_reg];
            tx_send_reg <= 1'b1;
            timer_reg   <= '0;
            state_reg   <= SEND;
          end
        end
        SEND: begin
          timer_reg <= timer_reg + 1'b1;
          if (bus.tx_busy) begin
            tx_send_reg <= 1'b0;
            state_reg   <= WAIT_DONE;
          end else if (timeout_hit) begin
            // The head byte is not popped; IDLE retries it.
            tx_send_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        WAIT_DONE: begin
          tx_send_reg <= 1'b0;
          if (!bus.tx_busy) state_reg <= IDLE;
        end
        default: begin
          tx_send_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign bus.d_in       = d_in_reg;
  assign bus.tx_send    = tx_send_reg;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.count      = count_reg;
  assign bus.overflow   = overflow_reg;
  assign bus.tx_timeout = tx_timeout_reg;
endmodule
